// File: rtl/adc_test_pkg.sv
// Shared types and constants for the ADC test-pattern sequencer and its sibling checker.
package adc_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SKIP,
        ARM,
        RUN,
        DRAIN,
        LATCH,
        DONE
    } state_t;

    localparam int DEF_SETTLE_CYCLES = 64;
    localparam int DEF_SKIP_SAMPLES  = 2;
    localparam int DEF_TEST_SAMPLES  = 1024;

    // LTC2387 digital test pattern, compared by the checker on every counted sample
    localparam logic [17:0] PATTERN = 18'b11_0011_0000_1111_1100;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/adc_test_sequencer.sv
// Sequences the ADC test-pattern check channel by channel and drives the shared checker.
// Optional per-channel watchdog and timeout_mask output: define ADC_TEST_TIMEOUT_EN.
module adc_test_sequencer
    import adc_test_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int SKIP_SAMPLES   = DEF_SKIP_SAMPLES,
    parameter int TEST_SAMPLES   = DEF_TEST_SAMPLES,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       abort,
    input  logic [NUM_CH-1:0]                          adc_valid,
    output logic                                       adc_testpat,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    output logic                                       chk_start,
    input  logic [31:0]                                chk_matches,
    input  logic [31:0]                                chk_mismatches,
    output logic                                       busy,
    output logic                                       done,
    output logic [NUM_CH-1:0]                          pass_mask,
`ifdef ADC_TEST_TIMEOUT_EN
    output logic [NUM_CH-1:0]                          timeout_mask,
`endif
    output logic [31:0]                                err_total
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SET_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int SMP_MAX = (TEST_SAMPLES > SKIP_SAMPLES) ? TEST_SAMPLES : SKIP_SAMPLES;
    localparam int SMP_W   = $clog2(SMP_MAX + 1);

    // Elaboration-time guard on the legal parameter ranges
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH must be 1..16");
    end
    if (SETTLE_CYCLES < 1 || SKIP_SAMPLES < 2 || TEST_SAMPLES < 1) begin : g_bad_counts
        $error("SETTLE_CYCLES >= 1, SKIP_SAMPLES >= 2, TEST_SAMPLES >= 1 required");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t             state;
    logic               start_q;
    logic [SET_W-1:0]   cyc_cnt;
    logic [SMP_W-1:0]   smp_cnt;
    logic               v;
    logic               start_edge;
    logic               last_ch;
    logic               pass_now;

    assign v          = adc_valid[ch_sel];
    assign start_edge = start & ~start_q;
    assign last_ch    = (ch_sel == CH_W'(NUM_CH - 1));
    assign pass_now   = (chk_mismatches == 32'd0) && (chk_matches == 32'(TEST_SAMPLES));

`ifdef ADC_TEST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog;
    logic            wd_expire;

    assign wd_expire = !v && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            start_q     <= 1'b0;
            cyc_cnt     <= '0;
            smp_cnt     <= '0;
            adc_testpat <= 1'b0;
            ch_sel      <= '0;
            chk_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_mask   <= '0;
            err_total   <= '0;
`ifdef ADC_TEST_TIMEOUT_EN
            wdog         <= '0;
            timeout_mask <= '0;
`endif
        end else begin
            start_q <= start;
            // abort outranks everything, including a start edge seen in the same cycle
            if (abort && state != IDLE) begin
                chk_start   <= 1'b0;
                adc_testpat <= 1'b0;
                busy        <= 1'b0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_edge && !abort) begin
                            pass_mask   <= '0;
                            err_total   <= '0;
                            done        <= 1'b0;
                            ch_sel      <= '0;
                            adc_testpat <= 1'b1;
                            busy        <= 1'b1;
                            cyc_cnt     <= '0;
`ifdef ADC_TEST_TIMEOUT_EN
                            timeout_mask <= '0;
`endif
                            state       <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (cyc_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
                            smp_cnt <= '0;
`ifdef ADC_TEST_TIMEOUT_EN
                            wdog    <= '0;
`endif
                            state   <= SKIP;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end
                    SKIP: begin
`ifdef ADC_TEST_TIMEOUT_EN
                        wdog <= v ? '0 : wdog + 1'b1;
                        if (wd_expire) begin
                            chk_start            <= 1'b0;
                            timeout_mask[ch_sel] <= 1'b1;
                            if (last_ch) begin
                                adc_testpat <= 1'b0;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                state       <= DONE;
                            end else begin
                                ch_sel  <= ch_sel + 1'b1;
                                cyc_cnt <= '0;
                                state   <= SETTLE;
                            end
                        end else
`endif
                        if (v) begin
                            if (smp_cnt == SMP_W'(SKIP_SAMPLES - 1)) begin
                                chk_start <= 1'b1;
                                state     <= ARM;
                            end else begin
                                smp_cnt <= smp_cnt + 1'b1;
                            end
                        end
                    end
                    ARM: begin
                        // checker clears its counters this cycle; samples here are not counted
                        smp_cnt <= '0;
`ifdef ADC_TEST_TIMEOUT_EN
                        wdog    <= '0;
`endif
                        state   <= RUN;
                    end
                    RUN: begin
`ifdef ADC_TEST_TIMEOUT_EN
                        wdog <= v ? '0 : wdog + 1'b1;
                        if (wd_expire) begin
                            chk_start            <= 1'b0;
                            timeout_mask[ch_sel] <= 1'b1;
                            if (last_ch) begin
                                adc_testpat <= 1'b0;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                state       <= DONE;
                            end else begin
                                ch_sel  <= ch_sel + 1'b1;
                                cyc_cnt <= '0;
                                state   <= SETTLE;
                            end
                        end else
`endif
                        if (v) begin
                            if (smp_cnt == SMP_W'(TEST_SAMPLES - 1)) begin
                                chk_start <= 1'b0;
                                state     <= DRAIN;
                            end else begin
                                smp_cnt <= smp_cnt + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        state <= LATCH;
                    end
                    LATCH: begin
                        pass_mask[ch_sel] <= pass_now;
                        err_total         <= sat_add32(err_total, chk_mismatches);
                        if (last_ch) begin
                            adc_testpat <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            ch_sel  <= ch_sel + 1'b1;
                            cyc_cnt <= '0;
                            state   <= SETTLE;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_test_sequencer.sv
// Scoreboard bench for adc_test_sequencer with a behavioural pattern checker alongside it.
module tb_adc_test_sequencer;
    import adc_test_pkg::*;

    localparam int NCH = 2;
    localparam int SET = 4;
    localparam int SKP = 2;
    localparam int TST = 8;
    localparam int TMO = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  adc_valid;
    logic        adc_testpat;
    logic [0:0]  ch_sel;
    logic        chk_start;
    logic [31:0] chk_matches;
    logic [31:0] chk_mismatches;
    logic        busy;
    logic        done;
    logic [1:0]  pass_mask;
    logic [31:0] err_total;
`ifdef ADC_TEST_TIMEOUT_EN
    logic [1:0]  timeout_mask;
`endif

    adc_test_sequencer #(
        .NUM_CH(NCH), .SETTLE_CYCLES(SET), .SKIP_SAMPLES(SKP),
        .TEST_SAMPLES(TST), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .adc_valid(adc_valid),
        .adc_testpat(adc_testpat), .ch_sel(ch_sel), .chk_start(chk_start),
        .chk_matches(chk_matches), .chk_mismatches(chk_mismatches),
        .busy(busy), .done(done), .pass_mask(pass_mask),
`ifdef ADC_TEST_TIMEOUT_EN
        .timeout_mask(timeout_mask),
`endif
        .err_total(err_total)
    );

    always #5 clk = ~clk;

    // Valid on every second cycle, per-channel enable mask
    logic       vtog;
    logic [1:0] vmask;
    always @(posedge clk) vtog <= rst ? 1'b0 : ~vtog;
    assign adc_valid = {2{vtog}} & vmask;

    // Pattern checker model: mode 1 corrupts the first 3 counted samples of channel 1,
    // mode 2 corrupts every sample outside the check window.
    int          mode;
    int          bad_cnt;
    logic        chk_q;
    logic        bad;
    logic [17:0] smp;
    always_comb begin
        bad = 1'b0;
        case (mode)
            1: bad = (ch_sel == 1'b1) && (bad_cnt < 3);
            2: bad = !chk_start;
            default: bad = 1'b0;
        endcase
        smp = bad ? (PATTERN ^ 18'h1) : PATTERN;
    end

    always @(posedge clk) begin
        if (rst) begin
            chk_q          <= 1'b0;
            chk_matches    <= '0;
            chk_mismatches <= '0;
            bad_cnt        <= 0;
        end else begin
            chk_q <= chk_start;
            if (chk_start && !chk_q) begin
                chk_matches    <= '0;
                chk_mismatches <= '0;
                bad_cnt        <= 0;
            end else if (chk_start && adc_valid[ch_sel]) begin
                if (smp == PATTERN) chk_matches <= chk_matches + 1;
                else begin
                    chk_mismatches <= chk_mismatches + 1;
                    bad_cnt        <= bad_cnt + 1;
                end
            end
        end
    end

    typedef struct {
        logic        d;
        logic [1:0]  pm;
        logic [31:0] et;
        logic [1:0]  tm;
    } res_t;
    typedef struct {
        logic [31:0] m;
        logic [31:0] mm;
    } ck_t;

    res_t rq[$];
    ck_t  cq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic push_res(input logic d, input logic [1:0] pm, input logic [31:0] et,
                            input logic [1:0] tm);
        res_t r;
        r.d = d; r.pm = pm; r.et = et; r.tm = tm;
        rq.push_back(r);
    endtask

    task automatic push_ck(input logic [31:0] m, input logic [31:0] mm);
        ck_t c;
        c.m = m; c.mm = mm;
        cq.push_back(c);
    endtask

    // Monitor: a check window closing while busy, and the end of every sequence
    logic busy_q = 1'b0;
    logic cs_q   = 1'b0;
    res_t er;
    ck_t  ec;
    always @(negedge clk) begin
        if (cs_q && !chk_start && busy) begin
            if (cq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_window: ch_sel=%0d", ch_sel);
            end else begin
                ec = cq.pop_front();
                chk("chk_matches", chk_matches, ec.m);
                chk("chk_mismatches", chk_mismatches, ec.mm);
            end
        end
        if (busy_q && !busy) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_end: done=%0b pass_mask=%0b", done, pass_mask);
            end else begin
                er = rq.pop_front();
                chk("end_done", 32'(done), 32'(er.d));
                chk("end_pass_mask", 32'(pass_mask), 32'(er.pm));
                chk("end_err_total", err_total, er.et);
                chk("end_testpat", 32'(adc_testpat), 32'd0);
                chk("end_chk_start", 32'(chk_start), 32'd0);
`ifdef ADC_TEST_TIMEOUT_EN
                chk("end_timeout_mask", 32'(timeout_mask), 32'(er.tm));
`endif
            end
        end
        busy_q <= busy;
        cs_q   <= chk_start;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        for (n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL %s_timeout: busy still 1 after 1000 cycles, expected 0", name);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0; vmask = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_testpat", 32'(adc_testpat), 32'd0);
        chk("rst_chk_start", 32'(chk_start), 32'd0);
        chk("rst_ch_sel", 32'(ch_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass_mask", 32'(pass_mask), 32'd0);
        chk("rst_err_total", err_total, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: clean pattern on both channels
        mode = 0;
        push_ck(8, 0); push_ck(8, 0); push_res(1'b1, 2'b11, 0, 2'b00);
        pulse_start();
        chk("t1_testpat_after_start", 32'(adc_testpat), 32'd1);
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        wait_end("t1");

        // 2: three bad samples inside channel 1's window
        mode = 1;
        push_ck(8, 0); push_ck(5, 3); push_res(1'b1, 2'b01, 3, 2'b00);
        pulse_start();
        wait_end("t2");

        // 3: bad samples only before the window; results from t2 must clear on start
        mode = 2;
        push_ck(8, 0); push_ck(8, 0); push_res(1'b1, 2'b11, 0, 2'b00);
        pulse_start();
        chk("t3_clear_done", 32'(done), 32'd0);
        chk("t3_clear_pass_mask", 32'(pass_mask), 32'd0);
        chk("t3_clear_err_total", err_total, 32'd0);
        wait_end("t3");

        // 4: abort during channel 1 RUN
        mode = 0;
        push_ck(8, 0); push_res(1'b0, 2'b01, 0, 2'b00);
        pulse_start();
        for (n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (ch_sel == 1'b1 && chk_start && chk_matches >= 2 && chk_matches <= 5) break;
        end
        chk("t4_reached_run", 32'(chk_start && ch_sel == 1'b1), 32'd1);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk("t4_testpat", 32'(adc_testpat), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_done", 32'(done), 32'd0);
        wait_end("t4");

        // 5: a second start while busy is ignored
        push_ck(8, 0); push_ck(8, 0); push_res(1'b1, 2'b11, 0, 2'b00);
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        wait_end("t5");
        repeat (20) @(negedge clk);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_done_held", 32'(done), 32'd1);

        // reset in the middle of a sequence
        push_res(1'b0, 2'b00, 0, 2'b00);
        pulse_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_testpat", 32'(adc_testpat), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifdef ADC_TEST_TIMEOUT_EN
        // 6: channel 0 never strobes; watchdog skips it
        vmask = 2'b10;
        push_ck(8, 0); push_res(1'b1, 2'b10, 0, 2'b01);
        pulse_start();
        wait_end("t6");
        vmask = 2'b11;
`endif

        chk("scoreboard_empty", 32'(rq.size() + cq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_test_sequencer.md
Name: adc_test_sequencer

Overview:
Controller that runs the ADC digital test-pattern check across NUM_CH ADC channels, one channel at a time, using a single shared pattern checker instantiated next to it. Per channel it:
- enables the ADC test-pattern mode and waits for it to settle;
- discards the first samples, which the LTC2387 requires;
- opens a fixed-length check window on the checker;
- latches a per-channel pass/fail result.

It sits between the register/control interface and the checker, and is the only driver of the checker's start and channel-select inputs.

Parameters:
NUM_CH, 4, number of ADC channels sequenced (1..16)
SETTLE_CYCLES, 64, clk cycles between test-pattern enable and the first counted sample
SKIP_SAMPLES, 2, valid samples discarded before the check window (minimum 2 for LTC2387)
TEST_SAMPLES, 1024, valid samples checked per channel (minimum 1)
TIMEOUT_CYCLES, 65536, watchdog limit; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  rising edge begins a full sequence; ignored while busy
abort  in  1  level; stops the sequence and returns to idle
adc_valid  in  NUM_CH  per-channel sample strobe
adc_testpat  out  1  ADC test-pattern mode enable
ch_sel  out  $clog2(NUM_CH) (min 1)  data mux select into the checker
chk_start  out  1  checker start level
chk_matches  in  32  checker match count
chk_mismatches  in  32  checker mismatch count
busy  out  1  sequence in progress
done  out  1  high from sequence completion until the next accepted start or rst
pass_mask  out  NUM_CH  bit i = channel i passed
err_total  out  32  sum of mismatches over all channels, saturating at 0xFFFF_FFFF

Behaviour:
- Reset values: all outputs 0 (adc_testpat, chk_start, ch_sel, busy, done, pass_mask, err_total); state IDLE.
- All outputs are registered.
- start is edge-detected with a registered copy.

State machine (v is adc_valid[ch_sel]):
- IDLE: on start rising edge with abort low → clear pass_mask, err_total and done; set ch_sel=0, adc_testpat=1, busy=1; go to SETTLE.
- SETTLE: count SETTLE_CYCLES clk cycles, then go to SKIP.
- SKIP: count SKIP_SAMPLES cycles with v=1, then go to ARM.
- ARM: exactly one cycle with chk_start=1. The checker clears its counters in this cycle, and no sample is counted by the sequencer. Go to RUN.
- RUN: chk_start stays 1. Count cycles with v=1. On the edge where the TEST_SAMPLES-th valid is seen, drop chk_start (it is 0 from the next cycle) and go to DRAIN.
- DRAIN: one cycle, so the checker's final counter update becomes visible. Go to LATCH.
- LATCH (one cycle):
  - pass_mask[ch_sel] = (chk_mismatches==0) && (chk_matches==TEST_SAMPLES);
  - err_total += chk_mismatches, saturating;
  - if ch_sel==NUM_CH-1 → DONE, else ch_sel+1 → SETTLE.
  - adc_testpat stays 1 between channels.
- DONE: adc_testpat=0, busy=0, done=1; go to IDLE.

Boundary conditions and widths:
- ch_sel changes only in LATCH and IDLE and never wraps; NUM_CH=1 is legal.
- Sample counter is $clog2(TEST_SAMPLES+1) bits and cleared on every entry to SKIP and RUN.
- abort in any non-IDLE state: next cycle chk_start=0, adc_testpat=0, busy=0, state=IDLE. done is not set; pass_mask keeps only bits already latched.
- abort and a start edge in the same cycle: abort wins; the start is dropped.
- A start edge while busy is ignored.
- rst mid-sequence: immediate return to the reset values above.
- Valids of non-selected channels are ignored.

Optional Feature:
Macro ADC_TEST_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles since the last v in SKIP and RUN.
  - If it reaches TIMEOUT_CYCLES: drop chk_start, leave pass_mask[ch_sel]=0, set timeout_mask[ch_sel]=1, and go to LATCH's channel-advance step without accumulating err_total.
  - Adds output timeout_mask (NUM_CH bits), reset 0, cleared on an accepted start.
- Undefined: no watchdog, no timeout_mask port; SKIP and RUN wait indefinitely for valids.

Decomposition:
- Package adc_test_pkg:
  - state enum (IDLE, SETTLE, SKIP, ARM, RUN, DRAIN, LATCH, DONE);
  - default constants for SETTLE_CYCLES, SKIP_SAMPLES and TEST_SAMPLES;
  - LTC2387 test PATTERN constant, 18'b11_0011_0000_1111_1100, shared with the checker;
  - 32-bit saturating-add function.
- No sub-module: the checker stays a separate sibling instance, and the counters are local to this block.

Test Plan:
Common setup: NUM_CH=2, SETTLE=4, SKIP=2, TEST=8, checker instantiated, valid every 2nd cycle.
1. Correct pattern on both channels, start pulse → adc_testpat high about 1 cycle after start; chk_start high for 1 ARM cycle plus the RUN window; done=1, pass_mask=2'b11, err_total=0; checker reports matches=8 per channel.
2. Channel 1 data corrupted on 3 of its 8 samples → pass_mask=2'b01, err_total=3.
3. Two bad samples inside the SKIP window only → not counted: pass_mask=2'b11, err_total=0.
4. abort asserted during channel 1 RUN → within 1 cycle adc_testpat=0, busy=0; done stays 0; pass_mask=2'b01.
5. Second start pulse while busy → ignored, single sequence completes. New start after done → pass_mask and err_total cleared in the cycle after start.
6. With ADC_TEST_TIMEOUT_EN and TIMEOUT=32, channel 0 valid held low → timeout_mask=2'b01, channel 1 still tested, pass_mask=2'b10, done=1.
